// File: rtl/sram_burst_controller.sv
// sram_burst_controller: bridges single CPU read/write requests onto an
// asynchronous SRAM with a fixed number of wait cycles per word access.
// Reads fetch an aligned burst of BURST_LEN words; writes store one word.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for rd_en/wr_en; ready drops combinationally on request
// READ    | BURST_LEN beats of WAIT_CYCLES clocks, one word captured per beat
// WRITE   | one beat of WAIT_CYCLES clocks with sram_we_n low, bus driven
// DONE    | one clock with ready high, then back to IDLE
module sram_burst_controller #(
    parameter int          ADDR_WIDTH  = 17,
    parameter int          DATA_WIDTH  = 32,
    parameter int          BURST_LEN   = 2,
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic                            wr_en,
    input  logic [31:0]                     address,
    input  logic [DATA_WIDTH-1:0]           write_data,
    output logic [BURST_LEN*DATA_WIDTH-1:0] read_data,
    output logic                            ready,
    inout  wire  [DATA_WIDTH-1:0]           sram_dq,
    output logic [ADDR_WIDTH-1:0]           sram_address,
    output logic                            sram_we_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Wait counter runs down from WAIT_CYCLES-1 to 0; 4 bits covers 15.
    localparam logic [3:0]            WAIT_LOAD   = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0]            LAST_BEAT   = 4'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_LEN_A = ADDR_WIDTH'(BURST_LEN);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wa_q, wa_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wait_q, wait_d;
    logic [3:0]              beat_q, beat_d;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   rword_q [BURST_LEN];

    logic [ADDR_WIDTH-1:0]   wa_raw;
    logic [ADDR_WIDTH-1:0]   wa_aligned;

    // Byte address relative to the window, converted to a word index and
    // truncated; reads snap down to the start of their burst.
    assign wa_raw     = ADDR_WIDTH'((address - BASE_ADDR) >> 2);
    assign wa_aligned = wa_raw - (wa_raw % BURST_LEN_A);

    // State, latched request and counters; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wa_q    <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state, counter updates, capture strobe and ready.
    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        capture = 1'b0;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = ~(rd_en | wr_en);
                if (wr_en) begin
                    state_d = ST_WRITE;
                    wa_d    = wa_raw;
                    wdata_d = write_data;
                    wait_d  = WAIT_LOAD;
                    beat_d  = '0;
                end else if (rd_en) begin
                    state_d = ST_READ;
                    wa_d    = wa_aligned;
                    wait_d  = WAIT_LOAD;
                    beat_d  = '0;
                end
            end
            ST_READ: begin
                if (wait_q == '0) begin
                    capture = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        wait_d = WAIT_LOAD;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_WRITE: begin
                if (wait_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the bus into the current beat's word on the beat's last edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BURST_LEN; k++) begin
                rword_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < BURST_LEN; k++) begin
                if (beat_q == 4'(k)) begin
                    rword_q[k] <= sram_dq;
                end
            end
        end
    end

    // Pack captured words, word k in slice k.
    always_comb begin
        read_data = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            read_data[k*DATA_WIDTH +: DATA_WIDTH] = rword_q[k];
        end
    end

    // SRAM address: burst base plus beat index while reading.
    always_comb begin
        sram_address = wa_q;
        if (state_q == ST_READ) begin
            sram_address = wa_q + ADDR_WIDTH'(beat_q);
        end
    end

    // Strobe and bus drive decode straight from the async-reset state, so
    // reset releases both without waiting for a clock.
    assign sram_we_n = (state_q != ST_WRITE);
    assign sram_dq   = (state_q == ST_WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_burst_controller.sv
// Bench for sram_burst_controller: two instances (default parameters and
// BURST_LEN=1/WAIT_CYCLES=1), each attached to a behavioural SRAM, checked
// against a word-level reference model of memory contents and timing.
module tb_sram_burst_controller;

    localparam int AW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en   [2];
    logic        wr_en   [2];
    logic        ready   [2];
    logic        we_n    [2];
    logic [31:0] address [2];
    logic [31:0] wdata   [2];
    logic [AW-1:0] sram_addr [2];
    logic [63:0] rdata0;
    logic [31:0] rdata1;
    wire  [31:0] dq0;
    wire  [31:0] dq1;

    logic [31:0] mem0 [0:(1<<AW)-1];
    logic [31:0] mem1 [0:(1<<AW)-1];
    logic [31:0] ref0 [logic [AW-1:0]];
    logic [31:0] ref1 [logic [AW-1:0]];
    logic [63:0] last_rd [2];

    int n_checks = 0;
    int n_errors = 0;

    sram_burst_controller dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(wdata[0]), .read_data(rdata0),
        .ready(ready[0]), .sram_dq(dq0), .sram_address(sram_addr[0]),
        .sram_we_n(we_n[0])
    );

    sram_burst_controller #(.BURST_LEN(1), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(wdata[1]), .read_data(rdata1),
        .ready(ready[1]), .sram_dq(dq1), .sram_address(sram_addr[1]),
        .sram_we_n(we_n[1])
    );

    // SRAM outputs data whenever a transfer is pending and it is not being written.
    assign dq0 = (we_n[0] && !ready[0] && !rst) ? mem0[sram_addr[0]] : 32'hzzzz_zzzz;
    assign dq1 = (we_n[1] && !ready[1] && !rst) ? mem1[sram_addr[1]] : 32'hzzzz_zzzz;

    function automatic logic [31:0] init_word(input int inst, input logic [AW-1:0] a);
        return (32'h9E37_79B9 * (32'(a) + 32'd1)) ^ ((inst == 1) ? 32'h5A5A_0000 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_get(input int inst, input logic [AW-1:0] a);
        if (inst == 0) return ref0.exists(a) ? ref0[a] : init_word(0, a);
        return ref1.exists(a) ? ref1[a] : init_word(1, a);
    endfunction

    function automatic logic [31:0] mem_get(input int inst, input logic [AW-1:0] a);
        return (inst == 0) ? mem0[a] : mem1[a];
    endfunction

    function automatic logic [63:0] get_rdata(input int inst);
        return (inst == 0) ? rdata0 : {32'd0, rdata1};
    endfunction

    // Behavioural SRAM: initial contents, preload, and writes sampled mid-cycle.
    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            mem0[a] = init_word(0, AW'(a));
            mem1[a] = init_word(1, AW'(a));
        end
        mem0[4] = 32'h1111_1111;
        mem0[5] = 32'h2222_2222;
        forever begin
            @(negedge clk);
            if (!rst && !we_n[0]) mem0[sram_addr[0]] = dq0;
            if (!rst && !we_n[1]) mem1[sram_addr[1]] = dq1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle_ready", 64'(ready[inst]), 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // One CPU transaction, entered and left 1 time unit after a rising edge.
    task automatic xact(input int inst, input bit do_wr, input bit do_rd,
                        input logic [31:0] addr, input logic [31:0] data, input bit keep);
        int bl;
        int wc;
        int busy;
        int we_low;
        bit done;
        logic [AW-1:0] wa;
        logic [AW-1:0] wa_al;
        logic [AW-1:0] exp_a;
        logic [63:0]   exp_rd;
        bl     = (inst == 0) ? 2 : 1;
        wc     = (inst == 0) ? 5 : 1;
        wa     = AW'((addr - 32'd1024) >> 2);
        wa_al  = wa - AW'(32'(wa) % bl);
        wr_en[inst]   = do_wr;
        rd_en[inst]   = do_rd;
        address[inst] = addr;
        wdata[inst]   = data;
        busy   = 0;
        we_low = 0;
        done   = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (ready[inst]) begin
                done = 1'b1;
                break;
            end
            busy++;
            if (c >= 2) begin
                exp_a = do_wr ? wa : wa_al + AW'((c - 2) / wc);
                check_val("sram_addr", 64'(sram_addr[inst]), 64'(exp_a));
                if (!we_n[inst]) we_low++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_val("timeout", 64'd0, 64'd1);
        check_val("latency", 64'(busy), do_wr ? 64'(1 + wc) : 64'(1 + bl * wc));
        check_val("we_low", 64'(we_low), do_wr ? 64'(wc) : 64'd0);
        if (do_wr) begin
            if (inst == 0) ref0[wa] = data;
            else           ref1[wa] = data;
            check_val("sram_word", 64'(mem_get(inst, wa)), 64'(data));
        end else begin
            exp_rd = '0;
            for (int k = 0; k < bl; k++) begin
                exp_rd |= 64'(ref_get(inst, wa_al + AW'(k))) << (32 * k);
            end
            last_rd[inst] = exp_rd;
        end
        check_val("read_data", get_rdata(inst), last_rd[inst]);
        @(posedge clk);
        #1;
        if (!keep) begin
            wr_en[inst] = 1'b0;
            rd_en[inst] = 1'b0;
        end
    endtask

    task automatic rand_xact(input int inst, input bit allow_gap);
        int op;
        logic [31:0] a;
        bit keep;
        op = $urandom_range(0, 2);
        if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1023);
        else a = 32'd1024 + 32'($urandom_range(0, 40)) * 4 + 32'($urandom_range(0, 3));
        keep = 1'($urandom_range(0, 1));
        xact(inst, op != 0, op != 1, a, $urandom, keep);
        if (!keep && allow_gap) idle(inst, $urandom_range(0, 2));
        wr_en[inst] = 1'b0;
        rd_en[inst] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_en[i] = 1'b0; wr_en[i] = 1'b0; address[i] = '0; wdata[i] = '0;
            last_rd[i] = '0;
        end
        ref0[4] = 32'h1111_1111;
        ref0[5] = 32'h2222_2222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val("rst_ready", 64'(ready[i]), 64'd1);
            check_val("rst_we_n", 64'(we_n[i]), 64'd1);
            check_val("rst_addr", 64'(sram_addr[i]), 64'd0);
            check_val("rst_rdata", get_rdata(i), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed: single write, burst read of preloaded words, rd+wr together.
        xact(0, 1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0);
        xact(0, 1'b0, 1'b1, 32'd1044, 32'h0, 1'b0);
        check_val("burst_read", rdata0, 64'h2222_2222_1111_1111);
        xact(0, 1'b1, 1'b1, 32'd1028, 32'h0BAD_F00D, 1'b0);
        check_val("both_keeps_rdata", rdata0, 64'h2222_2222_1111_1111);

        // Back-to-back write then read with the request held across DONE.
        xact(0, 1'b1, 1'b0, 32'd1032, 32'hCAFE_F00D, 1'b1);
        xact(0, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b1);
        check_val("b2b_low_word", 64'(rdata0[31:0]), 64'hCAFE_F00D);
        xact(0, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        idle(0, 2);

        // Reset in the third cycle of a write aborts it at once.
        wr_en[0] = 1'b1; address[0] = 32'd1024 + 32'd4000; wdata[0] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #2;
        check_val("pre_rst_we_n", 64'(we_n[0]), 64'd0);
        rst = 1'b1;
        wr_en[0] = 1'b0;
        #1;
        check_val("async_we_n", 64'(we_n[0]), 64'd1);
        check_val("async_addr", 64'(sram_addr[0]), 64'd0);
        check_val("async_rdata", rdata0, 64'd0);
        check_val("async_ready", 64'(ready[0]), 64'd1);
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(0, 1);

        // Randomized traffic on the default instance.
        for (int i = 0; i < 40; i++) rand_xact(0, 1'b1);
        idle(0, 1);

        // Minimum-latency instance: directed write/read then random traffic.
        xact(1, 1'b1, 1'b0, 32'd1032, 32'hA5A5_0F0F, 1'b0);
        xact(1, 1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        check_val("min_read", 64'(rdata1), 64'hA5A5_0F0F);
        for (int i = 0; i < 30; i++) rand_xact(1, 1'b1);
        idle(1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
